// File: rtl/mc_ctrl_fsm_hs_if.sv
// Handshake/control bundle between the multicycle control FSM and the
// instruction register, memories and datapath.
// master: the control FSM; slave: the memory/datapath side.
interface mc_ctrl_fsm_hs_if #(
   parameter int unsigned CNT_W = 32
);
   logic [31:0]      instrCode;
   logic             imemReady;
   logic             busReady;
   logic             mulDone;
   logic             imemReq;
   logic             PCEn;
   logic             irWe;
   logic             regFileWe;
   logic             aluSrcMuxSel;
   logic [3:0]       aluControl;
   logic [2:0]       strb;
   logic [2:0]       RFWDSrcMuxSel;
   logic             branch;
   logic             jal;
   logic             jalr;
   logic             busReq;
   logic             busWe;
   logic             mulStart;
   logic             illegal;
   logic             busTimeout;
   logic [CNT_W-1:0] instret;

   modport master (
      input  instrCode, imemReady, busReady, mulDone,
      output imemReq, PCEn, irWe, regFileWe, aluSrcMuxSel, aluControl, strb,
             RFWDSrcMuxSel, branch, jal, jalr, busReq, busWe, mulStart,
             illegal, busTimeout, instret
   );

   modport slave (
      output instrCode, imemReady, busReady, mulDone,
      input  imemReq, PCEn, irWe, regFileWe, aluSrcMuxSel, aluControl, strb,
             RFWDSrcMuxSel, branch, jal, jalr, busReq, busWe, mulStart,
             illegal, busTimeout, instret
   );
endinterface

// File: rtl/mc_ctrl_fsm_hs.sv
// Multicycle RV32I control FSM with ready/valid handshakes on fetch and
// data-memory access, a handshake watchdog, illegal-opcode trap and a
// retired-instruction counter.
// Optional macro M_EXT_EN: routes funct7 = 0000001 R-type to a multi-cycle
// M unit (M_EXE/M_WB); when undefined those encodings trap as illegal.
module mc_ctrl_fsm_hs #(
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   mc_ctrl_fsm_hs_if.master bus
);

   // Wait counter is wide enough to reach WAIT_MAX; it saturates so that the
   // M_EXE first-cycle detection still works with the watchdog disabled.
   localparam int unsigned     WC_W     = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(WAIT_MAX);
   localparam logic [WC_W-1:0] WC_SAT   = '1;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_L  = 7'b0000011;
   localparam logic [6:0] OP_B  = 7'b1100011;
   localparam logic [6:0] OP_LU = 7'b0110111;
   localparam logic [6:0] OP_AU = 7'b0010111;
   localparam logic [6:0] OP_J  = 7'b1101111;
   localparam logic [6:0] OP_JL = 7'b1100111;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SRAI  = 4'b1101;

   typedef enum logic [4:0] {
      FETCH, DECODE, R_EXE, I_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB,
      B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, M_EXE, M_WB, TRAP
   } state_e;

   state_e           state_q, state_d;
   logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic             illegal_q, illegal_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic             hs_wait;
   logic             hs_ready;

   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic [3:0]       op_field;

   logic             imem_req, pc_en, ir_we, rf_we, alu_src;
   logic [3:0]       alu_ctl;
   logic [2:0]       rfwd_sel;
   logic             br, jl, jlr, bus_req, bus_we, mul_start;

   assign opcode   = bus.instrCode[6:0];
   assign funct3   = bus.instrCode[14:12];
   assign funct7   = bus.instrCode[31:25];
   assign op_field = {bus.instrCode[30], funct3};

   // Register operand / destination fields belong to the datapath.
   logic unused_instr;
   assign unused_instr = ^{bus.instrCode[24:15], bus.instrCode[11:7]};

`ifndef M_EXT_EN
   logic unused_mul;
   assign unused_mul = bus.mulDone;
`endif

   // State register plus wait counter, sticky traps and retire counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         wait_cnt_q <= '0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         illegal_q  <= illegal_d;
         timeout_q  <= timeout_d;
         instret_q  <= instret_d;
      end
   end

   // Next-state, watchdog and retire-count logic.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      illegal_d  = illegal_q;
      timeout_d  = timeout_q;
      instret_d  = instret_q;
      hs_wait    = 1'b0;
      hs_ready   = 1'b0;

      case (state_q)
         FETCH: begin
            hs_wait  = 1'b1;
            hs_ready = bus.imemReady;
            if (bus.imemReady) state_d = DECODE;
         end
         DECODE: begin
            case (opcode)
               OP_R: begin
                  if (funct7 == F7_MULDIV) begin
`ifdef M_EXT_EN
                     state_d = M_EXE;
`else
                     state_d   = TRAP;
                     illegal_d = 1'b1;
`endif
                  end else begin
                     state_d = R_EXE;
                  end
               end
               OP_I:    state_d = I_EXE;
               OP_S:    state_d = S_EXE;
               OP_L:    state_d = L_EXE;
               OP_B:    state_d = B_EXE;
               OP_LU:   state_d = LU_EXE;
               OP_AU:   state_d = AU_EXE;
               OP_J:    state_d = J_EXE;
               OP_JL:   state_d = JL_EXE;
               default: begin
                  state_d   = TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, L_WB, M_WB:
            state_d = FETCH;
         S_EXE: state_d = S_MEM;
         L_EXE: state_d = L_MEM;
         S_MEM: begin
            hs_wait  = 1'b1;
            hs_ready = bus.busReady;
            if (bus.busReady) state_d = FETCH;
         end
         L_MEM: begin
            hs_wait  = 1'b1;
            hs_ready = bus.busReady;
            if (bus.busReady) state_d = L_WB;
         end
         M_EXE: begin
`ifdef M_EXT_EN
            hs_wait  = 1'b1;
            hs_ready = bus.mulDone;
            if (bus.mulDone) state_d = M_WB;
`else
            state_d = TRAP;
`endif
         end
         TRAP:    state_d = TRAP;
         default: state_d = FETCH;
      endcase

      // Ready at the limit wins because only the not-ready path can trap.
      if (hs_wait && !hs_ready) begin
         if ((WAIT_MAX != 0) && (wait_cnt_q == WC_LIMIT)) begin
            state_d   = TRAP;
            timeout_d = 1'b1;
         end else if (wait_cnt_q != WC_SAT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
      end

      if ((state_d == FETCH) && (state_q != FETCH)) instret_d = instret_q + 1'b1;
   end

   // Control outputs decoded from the current state and handshake inputs.
   always_comb begin
      imem_req  = 1'b0;
      pc_en     = 1'b0;
      ir_we     = 1'b0;
      rf_we     = 1'b0;
      alu_src   = 1'b0;
      alu_ctl   = ALU_ADD;
      rfwd_sel  = 3'b000;
      br        = 1'b0;
      jl        = 1'b0;
      jlr       = 1'b0;
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      mul_start = 1'b0;

      case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            if (bus.imemReady) begin
               pc_en = 1'b1;
               ir_we = 1'b1;
            end
         end
         R_EXE: begin
            rf_we   = 1'b1;
            alu_ctl = op_field;
         end
         I_EXE: begin
            rf_we   = 1'b1;
            alu_src = 1'b1;
            alu_ctl = (op_field == ALU_SRAI) ? ALU_SRAI : {1'b0, funct3};
         end
         B_EXE: begin
            br      = 1'b1;
            alu_ctl = op_field;
         end
         LU_EXE: begin
            rf_we    = 1'b1;
            rfwd_sel = 3'b010;
         end
         AU_EXE: begin
            rf_we    = 1'b1;
            rfwd_sel = 3'b011;
         end
         J_EXE: begin
            rf_we    = 1'b1;
            rfwd_sel = 3'b100;
            jl       = 1'b1;
         end
         JL_EXE: begin
            rf_we    = 1'b1;
            rfwd_sel = 3'b100;
            jl       = 1'b1;
            jlr      = 1'b1;
         end
         S_EXE: alu_src = 1'b1;
         L_EXE: alu_src = 1'b1;
         S_MEM: begin
            bus_req = 1'b1;
            bus_we  = 1'b1;
         end
         L_MEM: bus_req = 1'b1;
         L_WB: begin
            rf_we    = 1'b1;
            rfwd_sel = 3'b001;
         end
`ifdef M_EXT_EN
         // Counter is still zero only on the first M_EXE cycle.
         M_EXE: mul_start = (wait_cnt_q == '0);
         M_WB: begin
            rf_we    = 1'b1;
            rfwd_sel = 3'b101;
         end
`endif
         default: ;
      endcase
   end

   assign bus.imemReq       = imem_req;
   assign bus.PCEn          = pc_en;
   assign bus.irWe          = ir_we;
   assign bus.regFileWe     = rf_we;
   assign bus.aluSrcMuxSel  = alu_src;
   assign bus.aluControl    = alu_ctl;
   assign bus.strb          = funct3;
   assign bus.RFWDSrcMuxSel = rfwd_sel;
   assign bus.branch        = br;
   assign bus.jal           = jl;
   assign bus.jalr          = jlr;
   assign bus.busReq        = bus_req;
   assign bus.busWe         = bus_we;
   assign bus.mulStart      = mul_start;
   assign bus.illegal       = illegal_q;
   assign bus.busTimeout    = timeout_q;
   assign bus.instret       = instret_q;

endmodule

// File: tb/tb_mc_ctrl_fsm_hs.sv
// Directed, table-driven bench for mc_ctrl_fsm_hs (WAIT_MAX = 4).
// Each table row is one clock cycle: inputs applied after the falling edge,
// outputs compared 1 ns later, state advances on the next rising edge.
module tb_mc_ctrl_fsm_hs;

   localparam int unsigned CNT_W = 32;

   // Control bit order: imemReq PCEn irWe regFileWe aluSrc branch jal jalr busReq busWe mulStart
   localparam logic [10:0] C_IMR  = 11'h400;
   localparam logic [10:0] C_PC   = 11'h200;
   localparam logic [10:0] C_IR   = 11'h100;
   localparam logic [10:0] C_RW   = 11'h080;
   localparam logic [10:0] C_AS   = 11'h040;
   localparam logic [10:0] C_BR   = 11'h020;
   localparam logic [10:0] C_JAL  = 11'h010;
   localparam logic [10:0] C_JALR = 11'h008;
   localparam logic [10:0] C_BQ   = 11'h004;
   localparam logic [10:0] C_BW   = 11'h002;
   localparam logic [10:0] C_MS   = 11'h001;
   localparam logic [10:0] C_NONE = 11'h000;
   localparam logic [10:0] C_FET  = C_IMR | C_PC | C_IR;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h40208233;
   localparam logic [31:0] I_SRAI = 32'h4040D193;
   localparam logic [31:0] I_XORI = 32'hFFF0C093;
   localparam logic [31:0] I_BLT  = 32'h0020C463;
   localparam logic [31:0] I_LUI  = 32'h12345237;
   localparam logic [31:0] I_AUI  = 32'h00000297;
   localparam logic [31:0] I_JAL  = 32'h008000EF;
   localparam logic [31:0] I_JALR = 32'h000080E7;
   localparam logic [31:0] I_LW   = 32'h0000A283;
   localparam logic [31:0] I_SW   = 32'h0020A223;
   localparam logic [31:0] I_ILL  = 32'h0000007F;
   localparam logic [31:0] I_MUL  = 32'h022081B3;

   typedef struct packed {
      logic        rst;
      logic [31:0] instr;
      logic        ir;
      logic        br;
      logic        md;
      logic [10:0] ctl;
      logic [3:0]  alu;
      logic [2:0]  rf;
      logic        ill;
      logic        to;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[$];

   logic clk = 1'b0;
   logic reset = 1'b1;
   int unsigned n_chk = 0;
   int unsigned n_fail = 0;

   always #5 clk = ~clk;

   mc_ctrl_fsm_hs_if #(.CNT_W(CNT_W)) bus_if ();

   mc_ctrl_fsm_hs #(.WAIT_MAX(4), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   logic [10:0] ctl_act;
   assign ctl_act = {bus_if.imemReq, bus_if.PCEn, bus_if.irWe, bus_if.regFileWe,
                     bus_if.aluSrcMuxSel, bus_if.branch, bus_if.jal, bus_if.jalr,
                     bus_if.busReq, bus_if.busWe, bus_if.mulStart};

   function automatic void row(input logic rst, input logic [31:0] instr,
                               input logic ir, input logic br, input logic md,
                               input logic [10:0] ctl, input logic [3:0] alu,
                               input logic [2:0] rf, input logic ill, input logic to,
                               input logic [31:0] cnt);
      vec_t v;
      v.rst = rst; v.instr = instr; v.ir = ir; v.br = br; v.md = md;
      v.ctl = ctl; v.alu = alu; v.rf = rf; v.ill = ill; v.to = to; v.cnt = cnt;
      vecs.push_back(v);
   endfunction

   task automatic step(input logic rst, input logic [31:0] instr,
                       input logic ir, input logic br, input logic md);
      @(negedge clk);
      reset            = rst;
      bus_if.instrCode = instr;
      bus_if.imemReady = ir;
      bus_if.busReady  = br;
      bus_if.mulDone   = md;
      #1;
   endtask

   task automatic check_row(input int idx, input vec_t v);
      n_chk++;
      if (ctl_act !== v.ctl || bus_if.aluControl !== v.alu || bus_if.RFWDSrcMuxSel !== v.rf ||
          bus_if.strb !== v.instr[14:12] || bus_if.illegal !== v.ill ||
          bus_if.busTimeout !== v.to || bus_if.instret !== v.cnt) begin
         n_fail++;
         $display("FAIL row%0d: got ctl=%b alu=%b rf=%b strb=%b ill=%b to=%b instret=%0d; want ctl=%b alu=%b rf=%b strb=%b ill=%b to=%b instret=%0d",
                  idx, ctl_act, bus_if.aluControl, bus_if.RFWDSrcMuxSel, bus_if.strb,
                  bus_if.illegal, bus_if.busTimeout, bus_if.instret,
                  v.ctl, v.alu, v.rf, v.instr[14:12], v.ill, v.to, v.cnt);
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, want finish before 100000 ns");
      $fatal(1, "timeout");
   end

   initial begin
      bus_if.instrCode = '0;
      bus_if.imemReady = 1'b0;
      bus_if.busReady  = 1'b0;
      bus_if.mulDone   = 1'b0;

      // rst instr ir br md ctl alu rf ill to instret
      row(0, I_ADD, 1,0,0, C_FET,  4'h0, 3'd0, 0,0, 0);   // FETCH after reset
      row(0, I_ADD, 1,0,0, C_NONE, 4'h0, 3'd0, 0,0, 0);   // DECODE
      row(0, I_ADD, 1,0,0, C_RW,   4'h0, 3'd0, 0,0, 0);   // R_EXE add
      for (int i = 0; i < 4; i++)
         row(0, I_SUB, 0,0,0, C_IMR, 4'h0, 3'd0, 0,0, 1); // fetch stall
      row(0, I_SUB, 1,0,0, C_FET,  4'h0, 3'd0, 0,0, 1);   // ready at limit wins
      row(0, I_SUB, 1,0,0, C_NONE, 4'h0, 3'd0, 0,0, 1);
      row(0, I_SUB, 1,0,0, C_RW,   4'h8, 3'd0, 0,0, 1);   // R_EXE sub
      row(0, I_SRAI,1,0,0, C_FET,  4'h0, 3'd0, 0,0, 2);
      row(0, I_SRAI,1,0,0, C_NONE, 4'h0, 3'd0, 0,0, 2);
      row(0, I_SRAI,1,0,0, C_RW|C_AS, 4'hD, 3'd0, 0,0, 2);
      row(0, I_XORI,1,0,0, C_FET,  4'h0, 3'd0, 0,0, 3);
      row(0, I_XORI,1,0,0, C_NONE, 4'h0, 3'd0, 0,0, 3);
      row(0, I_XORI,1,0,0, C_RW|C_AS, 4'h4, 3'd0, 0,0, 3);
      row(0, I_BLT, 1,0,0, C_FET,  4'h0, 3'd0, 0,0, 4);
      row(0, I_BLT, 1,0,0, C_NONE, 4'h0, 3'd0, 0,0, 4);
      row(0, I_BLT, 1,0,0, C_BR,   4'h4, 3'd0, 0,0, 4);
      row(0, I_LUI, 1,0,0, C_FET,  4'h0, 3'd0, 0,0, 5);
      row(0, I_LUI, 1,0,0, C_NONE, 4'h0, 3'd0, 0,0, 5);
      row(0, I_LUI, 1,0,0, C_RW,   4'h0, 3'd2, 0,0, 5);
      row(0, I_AUI, 1,0,0, C_FET,  4'h0, 3'd0, 0,0, 6);
      row(0, I_AUI, 1,0,0, C_NONE, 4'h0, 3'd0, 0,0, 6);
      row(0, I_AUI, 1,0,0, C_RW,   4'h0, 3'd3, 0,0, 6);
      row(0, I_JAL, 1,0,0, C_FET,  4'h0, 3'd0, 0,0, 7);
      row(0, I_JAL, 1,0,0, C_NONE, 4'h0, 3'd0, 0,0, 7);
      row(0, I_JAL, 1,0,0, C_RW|C_JAL, 4'h0, 3'd4, 0,0, 7);
      row(0, I_JALR,1,0,0, C_FET,  4'h0, 3'd0, 0,0, 8);
      row(0, I_JALR,1,0,0, C_NONE, 4'h0, 3'd0, 0,0, 8);
      row(0, I_JALR,1,0,0, C_RW|C_JAL|C_JALR, 4'h0, 3'd4, 0,0, 8);
      row(0, I_LW,  1,0,0, C_FET,  4'h0, 3'd0, 0,0, 9);
      row(0, I_LW,  1,0,0, C_NONE, 4'h0, 3'd0, 0,0, 9);
      row(0, I_LW,  1,0,0, C_AS,   4'h0, 3'd0, 0,0, 9);   // L_EXE
      for (int i = 0; i < 3; i++)
         row(0, I_LW, 0,0,0, C_BQ, 4'h0, 3'd0, 0,0, 9);   // L_MEM waiting
      row(0, I_LW,  0,1,0, C_BQ,   4'h0, 3'd0, 0,0, 9);   // 4th L_MEM, ready
      row(0, I_LW,  0,0,0, C_RW,   4'h0, 3'd1, 0,0, 9);   // L_WB
      row(0, I_SW,  1,0,0, C_FET,  4'h0, 3'd0, 0,0, 10);
      row(0, I_SW,  1,0,0, C_NONE, 4'h0, 3'd0, 0,0, 10);
      row(0, I_SW,  1,0,0, C_AS,   4'h0, 3'd0, 0,0, 10);  // S_EXE
      row(0, I_SW,  0,0,0, C_BQ|C_BW, 4'h0, 3'd0, 0,0, 10);
      row(0, I_SW,  0,1,0, C_BQ|C_BW, 4'h0, 3'd0, 0,0, 10);
      row(0, I_ILL, 1,0,0, C_FET,  4'h0, 3'd0, 0,0, 11);
      row(0, I_ILL, 1,0,0, C_NONE, 4'h0, 3'd0, 0,0, 11);  // DECODE
      row(0, I_ILL, 1,1,1, C_NONE, 4'h0, 3'd0, 1,0, 11);  // TRAP
      row(0, I_ILL, 1,1,1, C_NONE, 4'h0, 3'd0, 1,0, 11);  // TRAP holds
      row(1, I_ILL, 1,1,1, C_NONE, 4'h0, 3'd0, 1,0, 11);  // reset pulse
      row(0, I_MUL, 1,0,0, C_FET,  4'h0, 3'd0, 0,0, 0);
      row(0, I_MUL, 1,0,0, C_NONE, 4'h0, 3'd0, 0,0, 0);   // DECODE mul
`ifdef M_EXT_EN
      row(0, I_MUL, 0,0,0, C_MS,   4'h0, 3'd0, 0,0, 0);   // M_EXE first cycle
      for (int i = 0; i < 3; i++)
         row(0, I_MUL, 0,0,0, C_NONE, 4'h0, 3'd0, 0,0, 0);
      row(0, I_MUL, 0,0,1, C_NONE, 4'h0, 3'd0, 0,0, 0);   // mulDone at limit
      row(0, I_MUL, 0,0,0, C_RW,   4'h0, 3'd5, 0,0, 0);   // M_WB
      row(0, I_MUL, 0,0,0, C_IMR,  4'h0, 3'd0, 0,0, 1);
`else
      row(0, I_MUL, 1,0,0, C_NONE, 4'h0, 3'd0, 1,0, 0);   // TRAP illegal
      row(1, I_MUL, 1,0,0, C_NONE, 4'h0, 3'd0, 1,0, 0);
      row(0, I_MUL, 0,0,0, C_IMR,  4'h0, 3'd0, 0,0, 0);
`endif

      step(1, I_ADD, 0, 0, 0);
      step(1, I_ADD, 0, 0, 0);
      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].instr, vecs[i].ir, vecs[i].br, vecs[i].md);
         check_row(i, vecs[i]);
      end

      // Store watchdog: busReady never arrives.
      step(1, I_SW, 0, 0, 0);
      step(0, I_SW, 1, 0, 0);
      step(0, I_SW, 1, 0, 0);
      step(0, I_SW, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step(0, I_SW, 0, 0, 0);
         chk($sformatf("wd_smem%0d", k), {61'd0, bus_if.busReq, bus_if.busWe, bus_if.busTimeout}, 64'b110);
      end
      step(0, I_SW, 1, 1, 0);
      chk("wd_trap", {59'd0, bus_if.imemReq, bus_if.busReq, bus_if.busWe, bus_if.busTimeout, bus_if.illegal}, 64'b00010);
      chk("wd_instret", 64'(bus_if.instret), 64'd0);
      step(0, I_SW, 1, 1, 0);
      chk("wd_hold", {62'd0, bus_if.imemReq, bus_if.busTimeout}, 64'b01);
      step(1, I_SW, 0, 0, 0);
      step(0, I_SW, 0, 0, 0);
      chk("wd_reset", {62'd0, bus_if.imemReq, bus_if.busTimeout}, 64'b10);

      // Reset asserted while a store is on the bus.
      step(0, I_ADD, 1, 0, 0);
      step(0, I_ADD, 1, 0, 0);
      step(0, I_ADD, 1, 0, 0);
      step(0, I_SW, 1, 0, 0);
      chk("mid_instret_pre", 64'(bus_if.instret), 64'd1);
      step(0, I_SW, 1, 0, 0);
      step(0, I_SW, 0, 0, 0);
      step(0, I_SW, 0, 0, 0);
      chk("mid_smem", {62'd0, bus_if.busReq, bus_if.busWe}, 64'b11);
      step(1, I_SW, 0, 0, 0);
      chk("mid_smem_rst", {62'd0, bus_if.busReq, bus_if.busWe}, 64'b11);
      step(0, I_SW, 0, 0, 0);
      chk("mid_fetch", {61'd0, bus_if.imemReq, bus_if.busReq, bus_if.busWe}, 64'b100);
      chk("mid_instret", 64'(bus_if.instret), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm_hs.md
Name: mc_ctrl_fsm_hs

Overview:
Parametrised multicycle RV32I control FSM for the next-generation multicycle core.
- Adds ready/valid handshakes on instruction fetch and data-memory access, so memories with variable latency are supported.
- Adds a watchdog that traps on a stalled handshake, illegal-opcode detection, and a retired-instruction counter.
- Drives the same datapath control set as the current multicycle core. Sits between the instruction register/bus interface and the datapath.

Parameters:
WAIT_MAX, 15, max cycles a handshake state may wait for ready before trapping; 0 disables the watchdog.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
instrCode  in  32  current instruction word
imemReady  in  1  instruction memory has valid data this cycle
busReady  in  1  data bus completed the access this cycle
mulDone  in  1  multi-cycle M unit result valid (used only with M_EXT_EN)
imemReq  out  1  instruction fetch request
PCEn  out  1  PC update enable
irWe  out  1  instruction register write enable
regFileWe  out  1  register file write enable
aluSrcMuxSel  out  1  0 = rs2, 1 = immediate
aluControl  out  4  ALU op; ADD = 4'b0000
strb  out  3  equals instrCode[14:12]
RFWDSrcMuxSel  out  3  000 ALU, 001 load, 010 LUI, 011 AUIPC, 100 PC+4, 101 M result
branch, jal, jalr  out  1 each  PC-select controls
busReq  out  1  data bus request
busWe  out  1  data bus write
mulStart  out  1  one-cycle M-unit start pulse
illegal  out  1  sticky: illegal instruction trap
busTimeout  out  1  sticky: handshake watchdog trap
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: state = FETCH, wait counter = 0, instret = 0, illegal = 0, busTimeout = 0. All control outputs 0 except combinational imemReq = 1 in FETCH.
- Outputs are combinational from state and inputs. Any output not listed for a state is 0. aluControl defaults to ADD.
- Opcodes: R 0110011, I 0010011, S 0100011, L 0000011, B 1100011, LU 0110111, AU 0010111, J 1101111, JL 1100111.
- FETCH: imemReq = 1.
  - If imemReady = 1: PCEn = 1, irWe = 1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: no outputs. Dispatch on opcode to R_EXE, I_EXE, S_EXE, L_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE or JL_EXE. Any other opcode goes to TRAP and sets illegal.
- R_EXE: regFileWe = 1, aluControl = {instrCode[30], instrCode[14:12]}.
- I_EXE: regFileWe = 1, aluSrcMuxSel = 1. aluControl = 4'b1101 if the op field is 1101 (SRAI); otherwise {0, funct3}.
- B_EXE: branch = 1, aluControl = op field.
- LU_EXE: regFileWe = 1, RFWDSrcMuxSel = 010.
- AU_EXE: regFileWe = 1, RFWDSrcMuxSel = 011.
- J_EXE: regFileWe = 1, RFWDSrcMuxSel = 100, jal = 1.
- JL_EXE: as J_EXE, plus jalr = 1.
- All single-step EXE states above go to FETCH.
- S_EXE: aluSrcMuxSel = 1, go to S_MEM.
- S_MEM: busReq = 1, busWe = 1. Held until busReady = 1, then FETCH.
- L_EXE: aluSrcMuxSel = 1, go to L_MEM.
- L_MEM: busReq = 1. Held until busReady = 1, then L_WB.
- L_WB: regFileWe = 1, RFWDSrcMuxSel = 001, go to FETCH.
- Handshake waiting (FETCH, S_MEM, L_MEM, M_EXE):
  - Wait counter increments on each waiting cycle and clears on state exit.
  - If WAIT_MAX != 0 and the counter equals WAIT_MAX with ready still low, go to TRAP and set busTimeout.
  - Ready arriving in the same cycle the limit is hit wins: normal transition, no trap.
- TRAP: all controls 0, imemReq = 0. Stays in TRAP until reset. illegal and busTimeout hold their values.
- instret increments by 1 on every transition into FETCH from a non-FETCH state, excluding the exit from reset. Wraps modulo 2^CNT_W.
- Reset asserted mid-operation (for example during S_MEM with busWe high) returns to FETCH on the next edge. busWe deasserts on that edge.

Optional Feature:
M_EXT_EN
- Defined: R-type with funct7 = 0000001 goes to M_EXE.
  - M_EXE asserts mulStart on its first cycle only, then waits for mulDone, with the watchdog applied.
  - Then M_WB: regFileWe = 1, RFWDSrcMuxSel = 101, then FETCH.
- Undefined: funct7 = 0000001 R-type is illegal and goes to TRAP. mulStart is tied to 0.

Test Plan:
1. reset, imemReady = 1, instrCode = 0x002081B3 (add) -> FETCH/DECODE/R_EXE: regFileWe = 1 in the 3rd cycle, aluControl = 0000; instret = 1 after returning to FETCH.
2. instrCode = 0x0000A283 (lw), busReady low for 3 cycles -> busReq high for 4 L_MEM cycles, then L_WB with RFWDSrcMuxSel = 001.
3. instrCode = 0x0020A223 (sw), WAIT_MAX = 4, busReady never asserts -> busTimeout = 1 after 4 S_MEM wait cycles; FSM parks in TRAP with busWe = 0.
4. instrCode = 0x0000007F -> DECODE then TRAP, illegal = 1, imemReq = 0; a reset pulse clears illegal and instret.
5. M_EXT_EN defined, instrCode = 0x022081B3 (mul), mulDone after 5 cycles -> single mulStart pulse, then M_WB with RFWDSrcMuxSel = 101. M_EXT_EN undefined, same instruction -> illegal = 1.
6. Assert reset during S_MEM -> next edge: state FETCH, busWe = 0, instret = 0.
